// File: rtl/core_pkg.sv
// Core-wide widths and the IF->ID queue depth used where the queue is instantiated.
package core_pkg;
  localparam int unsigned ADDR_WIDTH  = 32;
  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned IF2ID_DEPTH = 2;
endpackage

// File: rtl/if2id_pkg.sv
// Payload carried from fetch to decode; fault is the LSB so ID can raise an access fault in order.
package if2id_pkg;
  typedef struct packed {
    logic [core_pkg::ADDR_WIDTH-1:0]  pc;
    logic [core_pkg::INSTR_WIDTH-1:0] instr;
    logic                             fault;
  } if2id_t;
endpackage

// File: rtl/if2id_queue.sv
// DEPTH-entry valid/ready FIFO between IF and ID with synchronous flush on redirect.
// Handshake flags come only from the registered count, so neither side sees a combinational path from the other.
module if2id_queue
  import if2id_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = core_pkg::ADDR_WIDTH,
  parameter int unsigned INSTR_WIDTH = core_pkg::INSTR_WIDTH,
  parameter int unsigned DEPTH       = 2,
  localparam int unsigned PTR_W      = $clog2(DEPTH),
  localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  if2id_t           in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output if2id_t           out_data_o,
  output logic [CNT_W-1:0] count_o
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("if2id_queue: DEPTH must be a power of two and at least 2");
  end

  if (ADDR_WIDTH + INSTR_WIDTH + 1 != $bits(if2id_t)) begin : g_width_chk
    $error("if2id_queue: ADDR_WIDTH/INSTR_WIDTH disagree with if2id_t");
  end

  if2id_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  assign in_ready_o  = count_q != CNT_W'(DEPTH);
  assign out_valid_o = count_q != '0;
  assign push        = in_valid_i && in_ready_o && !flush_i;
  assign pop         = out_valid_o && out_ready_i && !flush_i;
  assign out_data_o  = mem_q[rd_ptr_q];
  assign count_o     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left unreset; flush and reset only move the pointers.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_data_i;
  end

  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(pop && count_q == '0));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(push && count_q == CNT_W'(DEPTH)));

endmodule

// File: tb/tb_if2id_queue.sv
// Randomized and directed checks of if2id_queue at depths 2, 4 and 8 against a queue-based reference.
module tb_if2id_queue;
  import if2id_pkg::*;

  localparam int DEP [3] = '{core_pkg::IF2ID_DEPTH, 4, 8};

  logic   clk;
  logic   rstn;
  logic   flush     [3];
  logic   in_valid  [3];
  logic   in_ready  [3];
  logic   out_valid [3];
  logic   out_ready [3];
  if2id_t in_data   [3];
  if2id_t out_data  [3];
  logic [1:0] cnt2;
  logic [2:0] cnt4;
  logic [3:0] cnt8;
  logic [3:0] cnt_w [3];

  int n_checks = 0;
  int n_errors = 0;
  if2id_t mq [$];

  assign cnt_w[0] = {2'b00, cnt2};
  assign cnt_w[1] = {1'b0, cnt4};
  assign cnt_w[2] = cnt8;

  if2id_queue #(.DEPTH(DEP[0])) u_dut2 (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush[0]),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .in_data_i(in_data[0]),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .out_data_o(out_data[0]),
    .count_o(cnt2));

  if2id_queue #(.DEPTH(DEP[1])) u_dut4 (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush[1]),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .in_data_i(in_data[1]),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .out_data_o(out_data[1]),
    .count_o(cnt4));

  if2id_queue #(.DEPTH(DEP[2])) u_dut8 (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush[2]),
    .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]), .in_data_i(in_data[2]),
    .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2]), .out_data_o(out_data[2]),
    .count_o(cnt8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic if2id_t mk(input logic [31:0] pc, input logic [31:0] instr, input logic fault);
    if2id_t e;
    e.pc = pc;
    e.instr = instr;
    e.fault = fault;
    return e;
  endfunction

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      flush[k] = 1'b0;
      in_valid[k] = 1'b0;
      out_ready[k] = 1'b0;
      in_data[k] = '0;
    end
  endtask

  task automatic do_reset();
    idle_all();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    mq.delete();
  endtask

  // One clock on lane k: check outputs against the reference, then apply the handshake rules to it.
  task automatic cyc(input int k, input bit v, input bit r, input bit fl, input if2id_t d);
    bit push, pop;
    in_valid[k] = v;
    out_ready[k] = r;
    flush[k] = fl;
    in_data[k] = d;
    chk("in_ready", in_ready[k], mq.size() != DEP[k]);
    chk("out_valid", out_valid[k], mq.size() != 0);
    chk("count", cnt_w[k], mq.size());
    if (mq.size() != 0) chk("head", out_data[k], mq[0]);
    push = v && (mq.size() < DEP[k]) && !fl;
    pop  = r && (mq.size() != 0) && !fl;
    @(posedge clk);
    #1;
    if (fl) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(d);
    end
    in_valid[k] = 1'b0;
    out_ready[k] = 1'b0;
    flush[k] = 1'b0;
  endtask

  initial begin
    if2id_t d;
    idle_all();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid[0], 1'b0);
    chk("rst_in_ready", in_ready[0], 1'b1);
    chk("rst_count", cnt_w[0], 0);
    rstn = 1'b1;
    mq.delete();

    cyc(0, 1, 0, 0, mk(32'h0, 32'h0000_0013, 1'b0));
    chk("first_valid", out_valid[0], 1'b1);
    chk("first_data", out_data[0], mk(32'h0, 32'h0000_0013, 1'b0));

    // fill and drain at depth 4, including a rejected push while full
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, mk(32'(i * 4), $urandom, 1'b0));
    chk("fill_count", cnt_w[1], 4);
    chk("fill_ready", in_ready[1], 1'b0);
    cyc(1, 1, 1, 0, mk(32'hDEAD, 32'h0, 1'b0));
    chk("full_pop_count", cnt_w[1], 3);
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, mk(32'(i * 4), 32'h13, 1'b0));
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", out_data[1].pc, 32'(i * 4));
      cyc(1, 0, 1, 0, '0);
    end
    chk("drain_empty", out_valid[1], 1'b0);

    // simultaneous push/pop at depth 2, pointers wrap several times
    do_reset();
    cyc(0, 1, 0, 0, mk(32'h0, 32'h13, 1'b0));
    for (int i = 1; i <= 10; i++) begin
      chk("pp_pc", out_data[0].pc, 32'((i - 1) * 4));
      cyc(0, 1, 1, 0, mk(32'(i * 4), 32'h13, 1'b0));
      chk("pp_count", cnt_w[0], 1);
    end

    // flush with a concurrent push request
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, mk(32'(i * 4), 32'h13, 1'b0));
    cyc(1, 1, 1, 1, mk(32'h200, 32'h13, 1'b0));
    chk("flush_count", cnt_w[1], 0);
    chk("flush_valid", out_valid[1], 1'b0);
    cyc(1, 1, 0, 0, mk(32'h100, 32'h13, 1'b0));
    chk("post_flush_pc", out_data[1].pc, 32'h100);
    chk("post_flush_count", cnt_w[1], 1);

    // fault bit forwarded unchanged
    do_reset();
    cyc(0, 1, 0, 0, mk(32'h8000_0000, 32'h13, 1'b1));
    cyc(0, 1, 0, 0, mk(32'h8000_0004, 32'h13, 1'b0));
    chk("fault_set", out_data[0].fault, 1'b1);
    chk("fault_pc", out_data[0].pc, 32'h8000_0000);
    cyc(0, 0, 1, 0, '0);
    chk("fault_clear", out_data[0].fault, 1'b0);

    // asynchronous reset mid-operation
    do_reset();
    for (int i = 0; i < 5; i++) cyc(2, 1, 0, 0, mk($urandom, $urandom, 1'b0));
    #2;
    rstn = 1'b0;
    #1;
    chk("async_valid", out_valid[2], 1'b0);
    chk("async_count", cnt_w[2], 0);
    chk("async_ready", in_ready[2], 1'b1);
    mq.delete();
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // random stall regression on every depth
    for (int k = 0; k < 3; k++) begin
      do_reset();
      for (int n = 0; n < 3400; n++) begin
        d = mk($urandom, $urandom, 1'($urandom_range(0, 1)));
        cyc(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0, d);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
